// File: rtl/multiply_unit.sv
// Handshaked signed W x W -> 2W multiplier: collects two indexed operands, multiplies, then offers the product.
// Define MULTIPLY_PIPELINE_EN to add a PIPE state that registers the product one more time before DONE.
module multiply_unit #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           arg_valid,
  output logic           arg_ready,
  input  logic [W-1:0]   arg_data,
  input  logic           arg_addr,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [2*W-1:0] res_data
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
`ifdef MULTIPLY_PIPELINE_EN
    , PIPE = 2'd3
`endif
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   op0_q, op1_q;
  logic [1:0]     loaded_q;
  logic [1:0]     loaded_next;
  logic           arg_fire;
  logic           res_fire;
  logic [2*W-1:0] product;

  assign arg_fire    = arg_valid && arg_ready;
  assign res_fire    = res_valid && res_ready;
  assign loaded_next = loaded_q | (2'b01 << arg_addr);
  assign product     = $signed(op0_q) * $signed(op1_q);

  // NOTE: sequential state is written with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= LOAD;
    else      state_q <= state_d;
  end

  // NOTE: always_comb assigns a default first so no path leaves a signal unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD: if (arg_fire && loaded_next == 2'b11) state_d = MUL;
`ifdef MULTIPLY_PIPELINE_EN
      MUL:  state_d = PIPE;
      PIPE: state_d = DONE;
`else
      MUL:  state_d = DONE;
`endif
      DONE: if (res_fire) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    arg_ready = (state_q == LOAD);
    res_valid = (state_q == DONE);
  end

  // NOTE: operand registers are reset explicitly because a discarded partial set must read back as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op0_q <= '0;
      op1_q <= '0;
    end else if (arg_fire) begin
      if (arg_addr) op1_q <= arg_data;
      else          op0_q <= arg_data;
    end
  end

  // Flags are only ever cleared by a result transfer; a re-sent index just keeps its flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          loaded_q <= 2'b00;
    else if (res_fire) loaded_q <= 2'b00;
    else if (arg_fire) loaded_q <= loaded_next;
  end

`ifdef MULTIPLY_PIPELINE_EN
  logic [2*W-1:0] prod_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q   <= '0;
      res_data <= '0;
    end else begin
      if (state_q == MUL)  prod_q   <= product;
      if (state_q == PIPE) res_data <= prod_q;
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 res_data <= '0;
    else if (state_q == MUL)  res_data <= product;
  end
`endif

endmodule

// File: tb/tb_multiply_unit.sv
// Directed bench for multiply_unit: hand-computed products, ordering, overwrite, back-pressure and reset.
module tb_multiply_unit;

  localparam int W = 16;
`ifdef MULTIPLY_PIPELINE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           arg_valid = 1'b0;
  logic           arg_ready;
  logic [W-1:0]   arg_data = '0;
  logic           arg_addr = 1'b0;
  logic           res_valid;
  logic           res_ready = 1'b0;
  logic [2*W-1:0] res_data;

  int vectors = 0;
  int miscompares = 0;

  multiply_unit #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .arg_valid (arg_valid),
    .arg_ready (arg_ready),
    .arg_data  (arg_data),
    .arg_addr  (arg_addr),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2*W-1:0] observed, input logic [2*W-1:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand for exactly one edge; LOAD must be accepting.
  task automatic send(input logic addr, input logic [W-1:0] data);
    check("arg_ready_before_send", {31'd0, arg_ready}, 32'd1);
    arg_valid = 1'b1;
    arg_addr  = addr;
    arg_data  = data;
    step();
    arg_valid = 1'b0;
  endtask

  // Called right after the second operand's transfer edge; checks latency and the product.
  task automatic expect_result(input string tag, input logic [2*W-1:0] exp);
    for (int i = 1; i < LAT; i++) begin
      check({tag, "_not_yet_valid"}, {31'd0, res_valid}, 32'd0);
      step();
    end
    check({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
    check({tag, "_data"}, res_data, exp);
    check({tag, "_arg_ready_low"}, {31'd0, arg_ready}, 32'd0);
  endtask

  // Accept the pending product and confirm the return to LOAD.
  task automatic consume(input string tag);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, res_valid}, 32'd0);
    check({tag, "_arg_ready_back"}, {31'd0, arg_ready}, 32'd1);
  endtask

  initial begin
    #12;
    check("reset_arg_ready", {31'd0, arg_ready}, 32'd1);
    check("reset_res_valid", {31'd0, res_valid}, 32'd0);
    check("reset_res_data", res_data, 32'h0000_0000);
    rst = 1'b1;
    step();

    // Basic product, index order 0 then 1.
    send(1'b0, 16'h0003);
    check("first_operand_stays_load", {31'd0, arg_ready}, 32'd1);
    send(1'b1, 16'h0004);
    expect_result("mul_3x4", 32'h0000_000C);
    consume("mul_3x4");

    // Reverse order, -1 * -1.
    send(1'b1, 16'hFFFF);
    send(1'b0, 16'hFFFF);
    expect_result("mul_m1xm1", 32'h0000_0001);
    consume("mul_m1xm1");

    // Extreme operands.
    send(1'b0, 16'h8000);
    send(1'b1, 16'h8000);
    expect_result("mul_min_min", 32'h4000_0000);
    consume("mul_min_min");

    send(1'b0, 16'h8000);
    send(1'b1, 16'h7FFF);
    expect_result("mul_min_max", 32'hC000_8000);

    // Back-pressure with stray arg_valid outside LOAD; nothing may move.
    arg_valid = 1'b1;
    arg_addr  = 1'b0;
    arg_data  = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid_held", {31'd0, res_valid}, 32'd1);
      check("bp_data_held", res_data, 32'hC000_8000);
      check("bp_arg_ready_low", {31'd0, arg_ready}, 32'd0);
    end
    arg_valid = 1'b0;
    consume("bp_release");

    // Re-send op0: last value wins, the FSM waits for op1.
    send(1'b0, 16'h0002);
    send(1'b0, 16'h0005);
    check("resend_stays_load", {31'd0, arg_ready}, 32'd1);
    check("resend_no_result", {31'd0, res_valid}, 32'd0);
    send(1'b1, 16'h0003);
    expect_result("resend_5x3", 32'h0000_000F);
    consume("resend_5x3");

    // res_ready held high ahead of time: exactly one valid cycle.
    res_ready = 1'b1;
    send(1'b0, 16'hFFFE);
    send(1'b1, 16'h0007);
    expect_result("early_ready", 32'hFFFF_FFF2);
    step();
    check("early_ready_one_cycle", {31'd0, res_valid}, 32'd0);
    check("early_ready_arg_ready", {31'd0, arg_ready}, 32'd1);
    step();
    check("early_ready_no_repeat", {31'd0, res_valid}, 32'd0);
    res_ready = 1'b0;

    // Reset after only op0 is loaded; the partial set must be discarded.
    send(1'b0, 16'h0009);
    #2 rst = 1'b0;
    #1;
    check("midreset_arg_ready", {31'd0, arg_ready}, 32'd1);
    check("midreset_res_valid", {31'd0, res_valid}, 32'd0);
    check("midreset_res_data", res_data, 32'h0000_0000);
    step();
    rst = 1'b1;
    step();
    send(1'b1, 16'h0007);
    check("post_reset_op0_flag_clear", {31'd0, arg_ready}, 32'd1);
    send(1'b0, 16'h0006);
    expect_result("post_reset_6x7", 32'h0000_002A);
    consume("post_reset_6x7");

    // Reset while a result is pending.
    send(1'b0, 16'h0011);
    send(1'b1, 16'h0002);
    for (int i = 1; i < LAT; i++) step();
    check("pending_valid", {31'd0, res_valid}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("pending_reset_valid", {31'd0, res_valid}, 32'd0);
    check("pending_reset_data", res_data, 32'h0000_0000);
    check("pending_reset_arg_ready", {31'd0, arg_ready}, 32'd1);
    step();
    rst = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multiply_unit.md
MULTIPLY_UNIT -- requirements
Module: multiply

Interface
REQ-001 SHALL have parameter W, default 16, giving the operand width in bits.
REQ-002 SHALL have the following ports, listed as name, direction, width, meaning:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- arg_valid  input  1  operand offered.
- arg_ready  output  1  operand slot accepts.
- arg_data  input  W  operand value, two's complement.
- arg_addr  input  1  operand index, 0 or 1.
- res_valid  output  1  product available.
- res_ready  input  1  consumer accepts product.
- res_data  output  2*W  signed product.

Function
REQ-003 SHALL store arg_data into operand register arg_addr on every edge where arg_valid && arg_ready (an arg transfer).
REQ-004 SHALL track one loaded flag per operand, set on that operand's transfer.
REQ-005 SHALL use FSM states LOAD, MUL, DONE.
- LOAD: arg_ready=1, res_valid=0.
- MUL: arg_ready=0, res_valid=0.
- DONE: arg_ready=0, res_valid=1.
REQ-006 SHALL move LOAD->MUL on the edge completing the second distinct operand transfer. Operands may arrive in either index order.
REQ-007 SHALL overwrite a stored operand if its index is re-sent while in LOAD (last value wins); the flag stays set and the FSM does not advance.
REQ-008 SHALL in MUL compute res_data = signed(op0) * signed(op1), full 2*W-bit result, no truncation or saturation, then move to DONE on the next edge.
REQ-009 SHALL hold res_valid and res_data stable in DONE until res_ready=1.
REQ-010 SHALL on the edge where res_valid && res_ready, clear both loaded flags and return to LOAD, making arg_ready=1 on the following cycle.
REQ-011 SHALL, with res_ready held high, assert res_valid for exactly one cycle per product.
REQ-012 SHALL have a latency of 2 edges from the second operand transfer to res_valid=1 (without REQ-016).
REQ-013 SHALL be insensitive to res_ready outside DONE and to arg_valid outside LOAD.
REQ-014 SHALL allow operands and the result handshake to run concurrently: the consumer may hold res_ready high before res_valid rises.

Reset
REQ-015 SHALL, on rst low at any time including mid-operation, immediately set:
- FSM=LOAD, flags clear, operands=0, res_data=0, res_valid=0, arg_ready=1.
- Any partial operand set or pending result is discarded.

Configuration
REQ-016 SHALL, when MULTIPLY_PIPELINE_EN is defined:
- add a state PIPE between MUL and DONE, registering the product once more;
- make the REQ-012 latency 3 edges.
Without the macro, PIPE does not exist and the REQ-012 latency is 2.

Verification
REQ-017 Load op0=0x0003 then op1=0x0004 -> res_data=0x0000000C, res_valid=1 exactly 2 edges after the second operand.
REQ-018 Load op1=0xFFFF then op0=0xFFFF (reverse order) -> res_data=0x00000001.
REQ-019 Extreme operands:
- 0x8000*0x8000 -> 0x40000000.
- 0x8000*0x7FFF -> 0xC0008000.
REQ-020 Back-pressure:
- Hold res_ready=0 for 5 cycles after res_valid -> res_data stable, arg_ready=0.
- Then raise res_ready -> one transfer, and arg_ready=1 on the next cycle.
REQ-021 Re-send op0=0x0002 then op0=0x0005, then op1=0x0003 -> 0x0000000F.
REQ-022 Assert rst low after only op0 is loaded -> all outputs reset; a fresh pair of operands then yields the correct product.
